// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory access arbiter.
//   state_t     : arbiter transaction phase (IDLE -> ACCESS -> RESP)
//   PORT_CPU    : id of the CPU load/store requester
//   PORT_DBG    : id of the debug/DMA loader requester
//   DEF_ADDR_W  : default word-address width (DM address[11:2])
//   DEF_DATA_W  : default data width
//   port_onehot : converts a 1-bit port id into a 2-bit one-hot grant vector
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    function automatic logic [1:0] port_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker (purely combinational).
//   valid [1:0] in  : request lines, bit 0 = CPU port, bit 1 = debug port
//   ptr         in  : preferred port when both request
//   gnt   [1:0] out : one-hot grant, all zero when nobody requests
//   id          out : id of the winning port (PORT_CPU when nobody requests)
// The pointer itself lives in the parent so it only advances on a real grant.
module rr_arb2
    import dm_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       id
);

    always_comb begin
        id  = PORT_CPU;
        gnt = 2'b00;
        if (valid == 2'b11) begin
            id = ptr;
        end else if (valid[1]) begin
            id = PORT_DBG;
        end else begin
            id = PORT_CPU;
        end
        if (|valid) begin
            gnt = port_onehot(id);
        end
    end

endmodule

// File: rtl/dm_access_arbiter.sv
// Shares the single-port data memory between the CPU load/store unit (port 0)
// and the debug/DMA loader (port 1). One transaction in flight, three cycles
// per transaction: grant in IDLE, memory access in ACCESS, response in RESP.
//   clk, rst_n                       : clock, synchronous active-low reset
//   reqN_valid/we/addr/wdata         : request command, held until reqN_ready
//   reqN_ready                       : combinational accept, only in IDLE
//   respN_valid                      : one-cycle completion pulse
//   respN_rdata                      : read data (holds last value otherwise)
//   dm_wr, dm_addr, dm_din           : registered controls to the DM
//   dm_dout                          : DM read data, one cycle after address
//   busy                             : high while a transaction is in flight
//   grant_id                         : owner of the current/last transaction
module dm_access_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_rdata,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,

    output logic              dm_wr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_din,
    input  logic [DATA_W-1:0] dm_dout,

    output logic              busy,
    output logic              grant_id
);

    // Per-port views of the request/response ports, index = port id.
    logic [1:0]             req_valid;
    logic [1:0]             req_we;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][DATA_W-1:0] req_wdata;
    logic [1:0]             req_ready;
    logic [1:0][DATA_W-1:0] resp_rdata;

    assign req_valid = {req1_valid, req0_valid};
    assign req_we    = {req1_we, req0_we};
    assign req_addr  = {req1_addr, req0_addr};
    assign req_wdata = {req1_wdata, req0_wdata};

    // Transaction state
    state_t              state_reg;
    logic                rr_ptr_reg;
    logic                op_write_reg;   // kind of the in-flight transaction
    logic                grant_id_reg;
    logic                busy_reg;
    logic                dm_wr_reg;
    logic [ADDR_W-1:0]   dm_addr_reg;
    logic [DATA_W-1:0]   dm_din_reg;
    logic [1:0]          resp_valid_reg;

    // Arbitration
    logic [1:0] arb_gnt;
    logic       arb_id;

    rr_arb2 u_rr_arb2 (
        .valid (req_valid),
        .ptr   (rr_ptr_reg),
        .gnt   (arb_gnt),
        .id    (arb_id)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= PORT_CPU;
            op_write_reg   <= 1'b0;
            grant_id_reg   <= PORT_CPU;
            busy_reg       <= 1'b0;
            dm_wr_reg      <= 1'b0;
            dm_addr_reg    <= '0;
            dm_din_reg     <= '0;
            resp_valid_reg <= 2'b00;
        end else begin
            resp_valid_reg <= 2'b00;
            case (state_reg)
                IDLE: begin
                    if (|arb_gnt) begin
                        dm_wr_reg    <= req_we[arb_id];
                        dm_addr_reg  <= req_addr[arb_id];
                        dm_din_reg   <= req_wdata[arb_id];
                        op_write_reg <= req_we[arb_id];
                        grant_id_reg <= arb_id;
                        rr_ptr_reg   <= ~arb_id;
                        busy_reg     <= 1'b1;
                        state_reg    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The DM commits the write / latches dout at this edge;
                    // the response is raised for the following cycle.
                    dm_wr_reg                    <= 1'b0;
                    resp_valid_reg[grant_id_reg] <= 1'b1;
                    state_reg                    <= RESP;
                end
                RESP: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    dm_wr_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Per-port ready and read-data path. During a read response the DM's own
    // output register already holds the data, so it is forwarded directly and
    // copied into the hold register so the value persists after the pulse.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [DATA_W-1:0] hold_reg;
        logic              rd_resp;

        assign rd_resp = resp_valid_reg[gi] && !op_write_reg;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                hold_reg <= '0;
            end else if (rd_resp) begin
                hold_reg <= dm_dout;
            end
        end

        assign req_ready[gi]  = rst_n && (state_reg == IDLE) && arb_gnt[gi];
        assign resp_rdata[gi] = rd_resp ? dm_dout : hold_reg;
    end

    assign req0_ready  = req_ready[0];
    assign req1_ready  = req_ready[1];
    assign resp0_valid = resp_valid_reg[0];
    assign resp1_valid = resp_valid_reg[1];
    assign resp0_rdata = resp_rdata[0];
    assign resp1_rdata = resp_rdata[1];

    assign dm_wr    = dm_wr_reg;
    assign dm_addr  = dm_addr_reg;
    assign dm_din   = dm_din_reg;
    assign busy     = busy_reg;
    assign grant_id = grant_id_reg;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Self-checking bench for dm_access_arbiter: a DM model on the memory side, a
// transaction-level reference model checked every cycle, a directed vector
// table, hand-written corner sequences and a randomized two-requester phase.
module tb_dm_access_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          req0_valid, req0_we, req0_ready, resp0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, resp0_rdata;
    logic          req1_valid, req1_we, req1_ready, resp1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, resp1_rdata;
    logic          dm_wr;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_din;
    logic [DW-1:0] dm_dout;
    logic          busy;
    logic          grant_id;

    // Stimulus, indexed by port
    logic          tb_valid [2];
    logic          tb_we    [2];
    logic [AW-1:0] tb_addr  [2];
    logic [DW-1:0] tb_wdata [2];

    assign req0_valid = tb_valid[0];
    assign req0_we    = tb_we[0];
    assign req0_addr  = tb_addr[0];
    assign req0_wdata = tb_wdata[0];
    assign req1_valid = tb_valid[1];
    assign req1_we    = tb_we[1];
    assign req1_addr  = tb_addr[1];
    assign req1_wdata = tb_wdata[1];

    dm_access_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_we     (req0_we),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .req0_ready  (req0_ready),
        .resp0_valid (resp0_valid),
        .resp0_rdata (resp0_rdata),
        .req1_valid  (req1_valid),
        .req1_we     (req1_we),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .req1_ready  (req1_ready),
        .resp1_valid (resp1_valid),
        .resp1_rdata (resp1_rdata),
        .dm_wr       (dm_wr),
        .dm_addr     (dm_addr),
        .dm_din      (dm_din),
        .dm_dout     (dm_dout),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: 1024x32, write on dm_wr, registered read.
    logic [DW-1:0] dm_mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) dm_mem[i] = '0;
        dm_dout = '0;
    end
    always @(posedge clk) begin
        if (dm_wr === 1'b1) dm_mem[dm_addr] <= dm_din;
        dm_dout <= dm_mem[dm_addr];
    end

    // Reference model: the current transaction and its age in cycles since
    // acceptance (1 = memory cycle, 2 = response cycle).
    bit            m_active;
    int            m_age;
    int            m_port;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit            m_pref;      // port favoured when both request
    bit            m_gid;       // owner of current/last transaction
    logic [DW-1:0] m_rdata [2];
    logic [DW-1:0] m_mem   [1024];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int last_acc;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active  = 0;
        m_age     = 0;
        m_pref    = 0;
        m_gid     = 0;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
    endtask

    // One clock cycle: called at a falling edge once inputs are set; compares
    // every DUT output with the model, then advances the model by one edge.
    task automatic step();
        bit er  [2];
        bit erv [2];
        bit ewr;
        #1;
        for (int p = 0; p < 2; p++) begin
            er[p]  = rst_n && !m_active && tb_valid[p] &&
                     (!tb_valid[1-p] || (m_pref == (p == 1)));
            erv[p] = m_active && (m_age == 2) && (m_port == p);
            if (erv[p] && !m_we) m_rdata[p] = m_mem[m_addr];
        end
        ewr = m_active && (m_age == 1) && m_we;
        chk("ready0",   {31'b0, req0_ready},  {31'b0, er[0]});
        chk("ready1",   {31'b0, req1_ready},  {31'b0, er[1]});
        chk("resp0",    {31'b0, resp0_valid}, {31'b0, erv[0]});
        chk("resp1",    {31'b0, resp1_valid}, {31'b0, erv[1]});
        chk("rdata0",   resp0_rdata, m_rdata[0]);
        chk("rdata1",   resp1_rdata, m_rdata[1]);
        chk("busy",     {31'b0, busy},     {31'b0, m_active});
        chk("dm_wr",    {31'b0, dm_wr},    {31'b0, ewr});
        chk("grant_id", {31'b0, grant_id}, {31'b0, m_gid});
        if (m_active && m_age == 1) begin
            chk("dm_addr", {22'b0, dm_addr}, {22'b0, m_addr});
            if (m_we) chk("dm_din", dm_din, m_wdata);
        end
        if (m_active && m_age == 2)
            $display("txn cycle=%0d port=%0d %s addr=%h data=%h", cyc, m_port,
                     m_we ? "WR" : "RD", m_addr, m_we ? m_wdata : m_rdata[m_port]);

        last_acc = -1;
        // The DM commits a write at the end of its memory cycle even if the
        // arbiter is being reset at that same edge.
        if (m_active && m_age == 1 && m_we) m_mem[m_addr] = m_wdata;
        if (!rst_n) begin
            model_reset();
        end else if (m_active) begin
            if (m_age == 2) m_active = 0;
            else            m_age++;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (er[p]) begin
                    m_active = 1;
                    m_age    = 1;
                    m_port   = p;
                    m_we     = tb_we[p];
                    m_addr   = tb_addr[p];
                    m_wdata  = tb_wdata[p];
                    m_pref   = (p == 0);
                    m_gid    = (p == 1);
                    last_acc = p;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Present a command on one port until accepted (bounded), then drop it.
    // Returns at the falling edge of the memory cycle.
    task automatic issue(input int p, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output bit ok);
        tb_valid[p] = 1'b1;
        tb_we[p]    = we;
        tb_addr[p]  = a;
        tb_wdata[p] = d;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            if (last_acc == p) ok = 1;
        end
        tb_valid[p] = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout port=%0d actual=no_grant required=grant", p);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && m_active; i++) step();
    endtask

    typedef struct {
        int            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    localparam int NV = 8;
    vec_t tbl [NV];

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit ok;
        bit pref0;
        int prev;
        int gcount;
        int n;

        tbl[0] = '{0, 1'b1, 10'h010, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{0, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{1, 1'b1, 10'h3FF, 32'h12345678, 32'h0};
        tbl[3] = '{0, 1'b0, 10'h3FF, 32'h0,        32'h12345678};
        tbl[4] = '{1, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF};
        tbl[5] = '{1, 1'b1, 10'h000, 32'hFFFFFFFF, 32'h0};
        tbl[6] = '{1, 1'b0, 10'h000, 32'h0,        32'hFFFFFFFF};
        tbl[7] = '{0, 1'b0, 10'h155, 32'h0,        32'h0};

        for (int i = 0; i < 1024; i++) m_mem[i] = '0;
        for (int p = 0; p < 2; p++) begin
            tb_valid[p] = 1'b1;
            tb_we[p]    = 1'b0;
            tb_addr[p]  = '0;
            tb_wdata[p] = '0;
        end

        // Reset held with both requesters active
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        repeat (3) step();
        chk("rst_dm_addr", {22'b0, dm_addr}, 32'h0);
        chk("rst_dm_din",  dm_din,      32'h0);
        chk("rst_rdata0",  resp0_rdata, 32'h0);
        chk("rst_rdata1",  resp1_rdata, 32'h0);
        rst_n = 1'b1;
        step();
        chk("first_grant", last_acc, 0);
        tb_valid[0] = 1'b0;
        tb_valid[1] = 1'b0;
        drain();
        step();

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            issue(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, ok);
            if (ok) begin
                chk("tbl_dm_wr", {31'b0, dm_wr}, {31'b0, tbl[i].we});
                step();
                chk("tbl_resp_valid", {31'b0, (tbl[i].port == 1) ? resp1_valid : resp0_valid}, 32'h1);
                chk("tbl_other_resp", {31'b0, (tbl[i].port == 1) ? resp0_valid : resp1_valid}, 32'h0);
                if (!tbl[i].we)
                    chk("tbl_rdata", (tbl[i].port == 1) ? resp1_rdata : resp0_rdata, tbl[i].exp_rdata);
                step();
            end
        end

        // Both ports requesting continuously: grants must alternate
        tb_valid[0] = 1'b1; tb_we[0] = 1'b0; tb_addr[0] = 10'h001;
        tb_valid[1] = 1'b1; tb_we[1] = 1'b0; tb_addr[1] = 10'h002;
        pref0  = m_pref;
        prev   = -1;
        gcount = 0;
        for (int i = 0; i < 40 && gcount < 6; i++) begin
            step();
            if (last_acc >= 0) begin
                chk("alt_grant", last_acc, (gcount == 0) ? int'(pref0) : 1 - prev);
                prev = last_acc;
                gcount++;
            end
        end
        chk("alt_count", gcount, 6);
        tb_valid[0] = 1'b0;
        tb_valid[1] = 1'b0;
        drain();

        // Port 1 arrives while port 0 is in its memory cycle
        issue(0, 1'b1, 10'h020, 32'hA5A5_5A5A, ok);
        tb_valid[1] = 1'b1; tb_we[1] = 1'b0; tb_addr[1] = 10'h020; tb_wdata[1] = '0;
        n = 0;
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            n++;
            if (last_acc == 1) ok = 1;
        end
        chk("late_grant_delay", n, 3);
        tb_valid[1] = 1'b0;
        step();
        chk("late_read_data", resp1_rdata, 32'hA5A5_5A5A);
        drain();

        // Reset during the memory cycle of a port-1 write: write lands, no response
        issue(1, 1'b1, 10'h030, 32'hCAFE_F00D, ok);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("rst_abort_resp1", {31'b0, resp1_valid}, 32'h0);
        issue(0, 1'b0, 10'h030, 32'h0, ok);
        step();
        chk("rst_access_write", resp0_rdata, 32'hCAFE_F00D);
        step();

        // Reset in the cycle a port-1 write would be granted: nothing happens
        tb_valid[1] = 1'b1; tb_we[1] = 1'b1; tb_addr[1] = 10'h031; tb_wdata[1] = 32'h1111_1111;
        rst_n = 1'b0;
        step();
        tb_valid[1] = 1'b0;
        rst_n = 1'b1;
        step();
        issue(0, 1'b0, 10'h031, 32'h0, ok);
        step();
        chk("rst_idle_no_write", resp0_rdata, 32'h0);
        step();

        // Full sweep: write data=addr everywhere, then read it all back
        for (int a = 0; a < 1024; a++) issue(a % 2, 1'b1, a[AW-1:0], DW'(a), ok);
        for (int a = 0; a < 1024; a++) begin
            issue((a + 1) % 2, 1'b0, a[AW-1:0], '0, ok);
            step();
            chk("sweep_rdata", ((a + 1) % 2 == 1) ? resp1_rdata : resp0_rdata, DW'(a));
        end
        drain();

        // Randomized traffic on both ports, small address window for RAW hits
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (tb_valid[p]) begin
                    if ($urandom_range(0, 15) == 0) tb_valid[p] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    tb_valid[p] = 1'b1;
                    tb_we[p]    = 1'($urandom_range(0, 1));
                    tb_addr[p]  = AW'($urandom_range(0, 15));
                    tb_wdata[p] = $urandom;
                end
            end
            step();
            if (last_acc >= 0) tb_valid[last_acc] = 1'b0;
        end
        tb_valid[0] = 1'b0;
        tb_valid[1] = 1'b0;
        drain();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
